// File: rtl/wbu.sv
`default_nettype none
// ============================================================================
//  Module      : wbu
//  Description : Write-back unit. Accepts one execute-stage result at a time,
//                waits for memory read data on loads, extracts and extends
//                the addressed byte/half/word, then performs a single-cycle
//                register-file write and retire pulse.
//                Optional feature macro: WBU_COMMIT_CNT_EN (retire counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module wbu #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      e_valid,
    output logic                      e_ready,
    input  logic                      e_regW,
    input  logic [REG_ADDR_WIDTH-1:0] e_regAddr,
    input  logic [DATA_WIDTH-1:0]     e_aluRes,
    input  logic                      e_isLoad,
    input  logic [2:0]                e_ldType,
    input  logic                      m_rvalid,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    output logic                      w_regW,
    output logic [REG_ADDR_WIDTH-1:0] w_regAddr,
    output logic [DATA_WIDTH-1:0]     w_regData,
    output logic                      commit,
    output logic [31:0]               commit_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_MEM = 2'd1;
    localparam logic [1:0] S_WRITE    = 2'd2;

    localparam logic [2:0] c_LD_LB  = 3'b000;
    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LBU = 3'b100;
    localparam logic [2:0] c_LD_LHU = 3'b101;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      r_reg_w;
    logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [2:0]                r_ld_type;
    logic [1:0]                r_ld_off;

    logic                      w_accept;
    logic                      w_mem_take;
    logic [7:0]                w_ld_byte;
    logic [15:0]               w_ld_half;
    logic [DATA_WIDTH-1:0]     w_ld_data;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs; only IDLE accepts, WRITE lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        e_ready     = 1'b0;
        commit      = 1'b0;
        w_regW      = 1'b0;
        w_accept    = 1'b0;
        w_mem_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                e_ready  = 1'b1;
                w_accept = e_valid;
                if (e_valid) begin
                    w_state_nxt = e_isLoad ? S_WAIT_MEM : S_WRITE;
                end
            end
            S_WAIT_MEM: begin
                w_mem_take = m_rvalid;
                if (m_rvalid) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                commit      = 1'b1;
                w_regW      = r_reg_w & (r_reg_addr != '0);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Load extraction: byte lane by offset, half lane by offset bit 1
    always_comb begin
        w_ld_byte = m_rdata[8*r_ld_off +: 8];
        w_ld_half = r_ld_off[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (r_ld_type)
            c_LD_LB:  w_ld_data = {{(DATA_WIDTH-8){w_ld_byte[7]}}, w_ld_byte};
            c_LD_LH:  w_ld_data = {{(DATA_WIDTH-16){w_ld_half[15]}}, w_ld_half};
            c_LD_LBU: w_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_ld_byte};
            c_LD_LHU: w_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_ld_half};
            default:  w_ld_data = m_rdata;
        endcase
    end

    // Capture registers; write data only changes when a value is finalized,
    // so w_regData keeps its previous value while a load is outstanding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_w    <= 1'b0;
            r_reg_addr <= '0;
            r_data     <= '0;
            r_ld_type  <= 3'b000;
            r_ld_off   <= 2'b00;
        end else begin
            if (w_accept) begin
                r_reg_w    <= e_regW;
                r_reg_addr <= e_regAddr;
                if (e_isLoad) begin
                    r_ld_type <= e_ldType;
                    r_ld_off  <= e_aluRes[1:0];
                end else begin
                    r_data <= e_aluRes;
                end
            end
            if (w_mem_take) begin
                r_data <= w_ld_data;
            end
        end
    end

    assign w_regAddr = r_reg_addr;
    assign w_regData = r_data;

`ifdef WBU_COMMIT_CNT_EN
    logic [31:0] r_commit_cnt;

    // Retire counter: every WRITE cycle counts, including writes to x0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_commit_cnt <= 32'd0;
        end else if (r_state == S_WRITE) begin
            r_commit_cnt <= r_commit_cnt + 32'd1;
        end
    end

    assign commit_cnt = r_commit_cnt;
`else
    assign commit_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5: register address width.
REQ-002 Parameter DATA_WIDTH, default 32: datapath width; the module SHALL support 32 only for load extraction.
REQ-003 clk  in  1: single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  in  1: reset, synchronous and active-low.
REQ-005 e_valid  in  1: execute-stage result valid.
REQ-006 e_ready  out  1: the WBU can accept a result this cycle.
REQ-007 e_regW  in  1: the result writes a register.
REQ-008 e_regAddr  in  REG_ADDR_WIDTH: destination register (rd).
REQ-009 e_aluRes  in  DATA_WIDTH: ALU result, or the load address when e_isLoad=1.
REQ-010 e_isLoad  in  1: the result comes from a memory load.
REQ-011 e_ldType  in  3: load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-012 m_rvalid  in  1: memory read data valid, single-cycle pulse.
REQ-013 m_rdata  in  DATA_WIDTH: word-aligned memory read data.
REQ-014 w_regW  out  1: register-file write enable.
REQ-015 w_regAddr  out  REG_ADDR_WIDTH: register-file write address.
REQ-016 w_regData  out  DATA_WIDTH: register-file write data.
REQ-017 commit  out  1: one-cycle pulse when an instruction retires.
REQ-018 commit_cnt  out  32: count of retired instructions.

Function
REQ-019 The WBU SHALL implement a three-state FSM with states IDLE, WAIT_MEM and WRITE.
REQ-020 e_ready SHALL be 1 only in IDLE; results presented in any other state are not accepted and SHALL be held by the producer.
REQ-021 In IDLE, on e_valid=1 with e_isLoad=0, the WBU SHALL capture regW, regAddr and aluRes, then go to WRITE.
REQ-022 In IDLE, on e_valid=1 with e_isLoad=1, the WBU SHALL capture regW, regAddr, ldType and aluRes[1:0], then go to WAIT_MEM.
REQ-023 In WAIT_MEM, on m_rvalid=1 the WBU SHALL capture the extracted load data and go to WRITE; otherwise it SHALL stay in WAIT_MEM with no timeout.
REQ-024 In IDLE and WRITE, m_rvalid SHALL be ignored.
REQ-025 Load extraction:
- LB/LBU: select byte aluRes[1:0].
- LH/LHU: select half aluRes[1]; aluRes[0] is ignored.
- LW, and any other ldType: the full word, with the offset ignored.
- LB and LH sign-extend; LBU and LHU zero-extend.
REQ-026 WRITE SHALL last exactly one cycle, then return to IDLE.
REQ-027 In WRITE: w_regW = captured regW AND (captured regAddr != 0), and commit = 1.
REQ-028 Outside WRITE: w_regW = 0 and commit = 0.
REQ-029 w_regAddr and w_regData SHALL be driven from capture registers and SHALL hold their last values outside WRITE.
REQ-030 Latency:
- Non-load: handshake in cycle N -> write in cycle N+1.
- Load: m_rvalid in cycle M -> write in cycle M+1.
REQ-031 Throughput is one non-load result per 2 cycles.

Reset
REQ-032 On rst_n=0 at posedge clk, the state SHALL become IDLE.
REQ-033 On reset, w_regW, commit, w_regAddr, w_regData and commit_cnt SHALL become 0.
REQ-034 Reset in WAIT_MEM or WRITE SHALL drop the pending result with no register write; a subsequent stale m_rvalid SHALL be ignored.
REQ-035 e_ready SHALL read 1 in the first cycle after reset deasserts.

Configuration
REQ-036 Macro WBU_COMMIT_CNT_EN, when defined, SHALL enable commit_cnt as a 32-bit counter that increments by 1 in every WRITE cycle, wraps 0xFFFFFFFF->0, and counts commits to x0.
REQ-037 When WBU_COMMIT_CNT_EN is undefined, commit_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-038 addi-style result: e_valid=1, e_regW=1, e_regAddr=5, e_aluRes=0x12345678, e_isLoad=0 -> next cycle w_regW=1, w_regAddr=5, w_regData=0x12345678, commit=1; e_ready=0 during that cycle.
REQ-039 Write to x0: e_regAddr=0, e_regW=1 -> w_regW=0, commit=1, commit_cnt increments (with WBU_COMMIT_CNT_EN).
REQ-040 Sign/zero extension: LB with aluRes[1:0]=2 and m_rdata=0x00800000 -> w_regData=0xFFFFFF80; LBU with the same inputs -> 0x00000080; LH with aluRes[1]=1 and m_rdata=0x8001_0000 -> 0xFFFF8001.
REQ-041 Load stall: m_rvalid delayed 7 cycles -> WBU stays in WAIT_MEM, e_ready=0, no write; write occurs 1 cycle after m_rvalid.
REQ-042 Reset mid-load: rst_n=0 during WAIT_MEM, then m_rvalid=1 after release -> no write, e_ready=1, commit_cnt=0.
REQ-043 Counter wrap: with WBU_COMMIT_CNT_EN, force the count to 0xFFFFFFFF, then one commit -> commit_cnt=0; with the macro undefined, commit_cnt stays 0 throughout.
